// File: rtl/mbox_ebox_responder_pkg.sv
// Shared EBOX/MBOX definitions for the memory request/response handshake:
// default widths, NXM timeout and the responder state type.
package mbox_ebox_responder_pkg;

    localparam int MBOX_ADDR_W      = 22;
    localparam int MBOX_DATA_W      = 36;
    localparam int MBOX_NXM_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RPW_WAIT,
        ST_WR,
        ST_RESP,
        ST_FAIL
    } mboxRespStateT;

endpackage

// File: rtl/mbox_nxm_timer.sv
// Non-existent-memory timeout counter: cleared while no memory request is
// outstanding, counts unacknowledged request cycles, flags the last one.
module mbox_nxm_timer #(
    parameter int NXM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = $clog2(NXM_TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NXM_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so a held request can never wrap back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mbox_ebox_responder.sv
// MBOX-side responder: accepts one EBOX read, write or read-pause-write,
// runs it on the backing-memory port and returns data/response strobes.
module mbox_ebox_responder
    import mbox_ebox_responder_pkg::*;
#(
    parameter int ADDR_W      = MBOX_ADDR_W,
    parameter int DATA_W      = MBOX_DATA_W,
    parameter int NXM_TIMEOUT = MBOX_NXM_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eboxReq,
    input  logic              eboxRead,
    input  logic              eboxWrite,
    input  logic [ADDR_W-1:0] eboxAddr,
    input  logic [DATA_W-1:0] eboxWData,
    input  logic              eboxWrGo,
    input  logic              eboxRetry,
    output logic              mboxBusy,
    output logic              mboxXfer,
    output logic [DATA_W-1:0] mboxRData,
    output logic              mboxRespIn,
    output logic              mboxPageFail,
    output logic              memReq,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData
);

    mboxRespStateT     state, state_next;
    logic              rpw_flag;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;
    logic              resp_p1;
    logic              fail_p1;
    logic              in_mem;
    logic              expired;
    logic              accept;
    logic              wrgo;
    logic              mem_done;
    logic              rd_done;
    logic              nxm;

    assign in_mem  = (state == ST_RD) || (state == ST_WR);
    assign rd_done = mem_done && (state == ST_RD);

    mbox_nxm_timer #(
        .NXM_TIMEOUT (NXM_TIMEOUT)
    ) u_nxm_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_mem),
        .enable  (in_mem && !memAck),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Retry outranks completion and timeout; an ack on the expiry cycle
    // outranks the timeout.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        wrgo       = 1'b0;
        mem_done   = 1'b0;
        nxm        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (eboxReq && (eboxRead || eboxWrite)) begin
                    accept     = 1'b1;
                    state_next = eboxRead ? ST_RD : ST_WR;
                end
            end
            ST_RD, ST_WR: begin
                if (eboxRetry) begin
                    state_next = ST_IDLE;
                end else if (memAck) begin
                    mem_done   = 1'b1;
                    state_next = (state == ST_RD && rpw_flag) ? ST_RPW_WAIT : ST_RESP;
                end else if (expired) begin
                    nxm        = 1'b1;
                    state_next = ST_FAIL;
                end
            end
            ST_RPW_WAIT: begin
                if (eboxRetry) begin
                    state_next = ST_IDLE;
                end else if (eboxWrGo) begin
                    wrgo       = 1'b1;
                    state_next = ST_WR;
                end
            end
            ST_RESP, ST_FAIL: state_next = ST_IDLE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // p0: request capture; p1: response strobes one cycle after memAck/expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_p0  <= '0;
            wdata_p0 <= '0;
            rpw_flag <= 1'b0;
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
            resp_p1  <= 1'b0;
            fail_p1  <= 1'b0;
        end else begin
            vld_p1  <= rd_done;
            resp_p1 <= mem_done || nxm;
            fail_p1 <= nxm;
            if (accept) begin
                addr_p0  <= eboxAddr;
                wdata_p0 <= eboxWData;
                rpw_flag <= eboxRead && eboxWrite;
            end
            if (wrgo) begin
                wdata_p0 <= eboxWData;
            end
            if (rd_done) begin
                rdata_p1 <= memRData;
            end
        end
    end

    assign mboxBusy     = (state != ST_IDLE);
    assign mboxXfer     = vld_p1;
    assign mboxRData    = rdata_p1;
    assign mboxRespIn   = resp_p1;
    assign mboxPageFail = fail_p1;
    assign memReq       = in_mem;
    assign memWrite     = (state == ST_WR);
    assign memAddr      = addr_p0;
    assign memWData     = wdata_p0;

endmodule

// File: tb/tb_mbox_ebox_responder.sv
// Bench for mbox_ebox_responder: directed scenarios plus randomized
// transactions checked against a word-level memory/latency reference model.
module tb_mbox_ebox_responder;
    import mbox_ebox_responder_pkg::*;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 36;
    localparam int NXM    = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              eboxReq = 1'b0, eboxRead = 1'b0, eboxWrite = 1'b0;
    logic [ADDR_W-1:0] eboxAddr = '0;
    logic [DATA_W-1:0] eboxWData = '0;
    logic              eboxWrGo = 1'b0, eboxRetry = 1'b0;
    logic              mboxBusy, mboxXfer, mboxRespIn, mboxPageFail;
    logic [DATA_W-1:0] mboxRData;
    logic              memReq, memWrite;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memAck = 1'b0;
    logic [DATA_W-1:0] memRData = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] phys_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] last_rd = '0;

    always #5 clk = ~clk;

    mbox_ebox_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NXM_TIMEOUT(NXM)
    ) dut (
        .clk(clk), .reset(reset),
        .eboxReq(eboxReq), .eboxRead(eboxRead), .eboxWrite(eboxWrite),
        .eboxAddr(eboxAddr), .eboxWData(eboxWData), .eboxWrGo(eboxWrGo),
        .eboxRetry(eboxRetry),
        .mboxBusy(mboxBusy), .mboxXfer(mboxXfer), .mboxRData(mboxRData),
        .mboxRespIn(mboxRespIn), .mboxPageFail(mboxPageFail),
        .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
        .memWData(memWData), .memAck(memAck), .memRData(memRData)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd36();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] phys_read(input logic [ADDR_W-1:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : '0;
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic with_retry);
        check("idle_before_req", 64'(mboxBusy), 64'd0);
        eboxReq   = 1'b1;
        eboxRead  = rd;
        eboxWrite = wr;
        eboxAddr  = a;
        eboxWData = d;
        eboxRetry = with_retry;
        tick();
        eboxReq   = 1'b0;
        eboxRead  = 1'($urandom_range(1, 0));
        eboxWrite = 1'($urandom_range(1, 0));
        eboxAddr  = ADDR_W'($urandom);
        eboxWData = rnd36();
        eboxRetry = 1'b0;
    endtask

    // Plays the backing memory: acks after 'lat' request cycles (never if
    // lat >= NXM) and reports the cycle of the response strobe.
    task automatic serve(input int lat, input logic is_wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, output int n_resp,
                         output logic xfer, output logic pf, output logic clean);
        int cnt;
        cnt = 0;
        n_resp = -1;
        xfer = 1'b0;
        pf = 1'b0;
        clean = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (mboxRespIn === 1'b1) begin
                n_resp = n;
                xfer = mboxXfer;
                pf = mboxPageFail;
                break;
            end
            if (mboxXfer !== 1'b0 || mboxPageFail !== 1'b0) clean = 1'b0;
            memAck = 1'b0;
            if (memReq === 1'b1) begin
                if (memWrite !== is_wr || memAddr !== a || (is_wr && memWData !== wd)) clean = 1'b0;
                if (cnt == lat) begin
                    memAck = 1'b1;
                    if (is_wr) phys_mem[memAddr] = memWData;
                    else memRData = phys_read(memAddr);
                end
                cnt++;
            end
            tick();
            memAck = 1'b0;
            memRData = rnd36();
        end
    endtask

    // kind: 0 read, 1 write, 2 read-pause-write
    task automatic txn(input int kind, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                       input int lat1, input int lat2, input int gap, input logic retry_in_idle);
        int   n, exp_n;
        logic x, pf, ok, exp_fail;
        issue(1'(kind != 1), 1'(kind != 0), a, d1, retry_in_idle);
        exp_fail = (lat1 >= NXM);
        exp_n    = exp_fail ? NXM : lat1 + 1;
        serve(lat1, 1'(kind == 1), a, d1, n, x, pf, ok);
        if (!exp_fail && kind != 1) last_rd = ref_read(a);
        if (!exp_fail && kind == 1) ref_mem[a] = d1;
        check("p1_latency", 64'(n), 64'(exp_n));
        check("p1_xfer", 64'(x), 64'(!exp_fail && kind != 1));
        check("p1_pagefail", 64'(pf), 64'(exp_fail));
        check("p1_rdata", 64'(mboxRData), 64'(last_rd));
        check("p1_stable", 64'(ok), 64'd1);
        check("p1_memreq_off", 64'(memReq), 64'd0);
        if (kind == 2 && !exp_fail) begin
            ok = 1'b1;
            for (int i = 0; i < gap; i++) begin
                tick();
                if (memReq !== 1'b0 || mboxBusy !== 1'b1 || mboxRespIn !== 1'b0) ok = 1'b0;
            end
            check("rpw_wait", 64'(ok), 64'd1);
            eboxWrGo  = 1'b1;
            eboxWData = d2;
            tick();
            eboxWrGo  = 1'b0;
            eboxWData = rnd36();
            exp_fail = (lat2 >= NXM);
            exp_n    = exp_fail ? NXM : lat2 + 1;
            serve(lat2, 1'b1, a, d2, n, x, pf, ok);
            if (!exp_fail) ref_mem[a] = d2;
            check("p2_latency", 64'(n), 64'(exp_n));
            check("p2_xfer", 64'(x), 64'd0);
            check("p2_pagefail", 64'(pf), 64'(exp_fail));
            check("p2_stable", 64'(ok), 64'd1);
            check("p2_rdata_held", 64'(mboxRData), 64'(last_rd));
        end
        tick();
        check("busy_after", 64'(mboxBusy), 64'd0);
        check("mem_vs_model", 64'(phys_read(a)), 64'(ref_read(a)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   kind, l1, l2, sel;
        logic [ADDR_W-1:0] a;

        // Asynchronous reset, checked before any clock edge
        #1 reset = 1'b1;
        #2;
        check("rst_memReq", 64'(memReq), 64'd0);
        check("rst_memWrite", 64'(memWrite), 64'd0);
        check("rst_busy", 64'(mboxBusy), 64'd0);
        check("rst_xfer", 64'(mboxXfer), 64'd0);
        check("rst_resp", 64'(mboxRespIn), 64'd0);
        check("rst_pagefail", 64'(mboxPageFail), 64'd0);
        check("rst_memAddr", 64'(memAddr), 64'd0);
        check("rst_memWData", 64'(memWData), 64'd0);
        check("rst_rdata", 64'(mboxRData), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        phys_mem[22'o1234] = 36'o123456701234;
        ref_mem[22'o1234]  = 36'o123456701234;
        phys_mem[22'o2000] = 36'o5;
        ref_mem[22'o2000]  = 36'o5;

        // Plain read, plain write, read-pause-write
        txn(0, 22'o1234, rnd36(), rnd36(), 3, 0, 1, 1'b0);
        txn(1, 22'o777, 36'o777777777777, rnd36(), 2, 0, 1, 1'b0);
        txn(2, 22'o2000, rnd36(), 36'o6, 1, 1, 10, 1'b0);
        check("rpw_final_word", 64'(phys_read(22'o2000)), 64'(36'o6));

        // NXM timeout, then ack arriving on the expiry cycle
        txn(0, 22'o4321, rnd36(), rnd36(), NXM + 100, 0, 1, 1'b0);
        txn(0, 22'o1234, rnd36(), rnd36(), NXM - 1, 0, 1, 1'b0);
        txn(1, 22'o4444, rnd36(), rnd36(), NXM + 100, 0, 1, 1'b0);

        // Retry two cycles into RD, then a late ack while idle
        issue(1'b1, 1'b0, 22'o1234, rnd36(), 1'b0);
        tick();
        tick();
        eboxRetry = 1'b1;
        tick();
        eboxRetry = 1'b0;
        check("retry_busy", 64'(mboxBusy), 64'd0);
        check("retry_memReq", 64'(memReq), 64'd0);
        check("retry_resp", 64'(mboxRespIn), 64'd0);
        memAck = 1'b1;
        memRData = 36'o707070707070;
        tick();
        memAck = 1'b0;
        check("late_ack_xfer", 64'(mboxXfer), 64'd0);
        check("late_ack_resp", 64'(mboxRespIn), 64'd0);
        check("late_ack_busy", 64'(mboxBusy), 64'd0);
        check("late_ack_rdata", 64'(mboxRData), 64'(last_rd));
        txn(0, 22'o1234, rnd36(), rnd36(), 2, 0, 1, 1'b0);

        // Asynchronous reset in the middle of a write
        issue(1'b0, 1'b1, 22'o3333, 36'o111122223333, 1'b0);
        tick();
        #2 reset = 1'b1;
        #1;
        check("arst_memReq", 64'(memReq), 64'd0);
        check("arst_busy", 64'(mboxBusy), 64'd0);
        check("arst_memWrite", 64'(memWrite), 64'd0);
        check("arst_memAddr", 64'(memAddr), 64'd0);
        #2 reset = 1'b0;
        last_rd = '0;
        tick();
        txn(1, 22'o3333, 36'o444455556666, rnd36(), 1, 0, 1, 1'b0);
        txn(0, 22'o3333, rnd36(), rnd36(), 0, 0, 1, 1'b0);

        // Randomized mix over a small address window
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(2, 0);
            l1   = $urandom_range(5, 0);
            l2   = $urandom_range(5, 0);
            sel  = $urandom_range(9, 0);
            if (sel == 0) l1 = NXM + 3;
            else if (sel == 1) l1 = NXM - 1;
            a = ADDR_W'($urandom_range(7, 0));
            txn(kind, a, rnd36(), rnd36(), l1, l2, $urandom_range(4, 1),
                1'($urandom_range(1, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
